sap_control_seq: RTL and testbench

- Control sequencer for the 8-bit microcomputer.
- Owns the one-hot T-state ring that times instruction fetch and execute. Decodes the 4-bit opcode from the instruction register and drives the active-high control lines of the PC, MAR, RAM, IR, A, B, ALU and output register.
- Supports variable-length instructions (early return to T1), pause via run, and HLT.

---
 rtl/sap_control_seq.sv | 119 +++++++++++
 tb/tb_sap_control_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sap_control_seq.sv
// rtl/sap_control_seq.sv - SAP-1 control sequencer: one-hot T-state ring, opcode decode, halt
// All state moves on the falling edge; controls decode combinationally from ring and opcode.
module sap_control_seq #(
   parameter int STEPS = 6,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             run,
   input  logic [OPW-1:0]   opcode,
   output logic [STEPS-1:0] t_state,
   output logic             pc_inc,
   output logic             pc_out,
   output logic             pc_load,
   output logic             mar_load,
   output logic             ram_out,
   output logic             ram_we,
   output logic             ir_load,
   output logic             ir_out,
   output logic             a_load,
   output logic             a_out,
   output logic             b_load,
   output logic             alu_out,
   output logic             alu_sub,
   output logic             out_load,
   output logic             halted
);

   localparam logic [OPW-1:0]   OP_LDA = OPW'(1);
   localparam logic [OPW-1:0]   OP_ADD = OPW'(2);
   localparam logic [OPW-1:0]   OP_SUB = OPW'(3);
   localparam logic [OPW-1:0]   OP_STA = OPW'(4);
   localparam logic [OPW-1:0]   OP_LDI = OPW'(5);
   localparam logic [OPW-1:0]   OP_JMP = OPW'(6);
   localparam logic [OPW-1:0]   OP_OUT = OPW'(14);
   localparam logic [OPW-1:0]   OP_HLT = OPW'(15);
   localparam logic [STEPS-1:0] T1     = {1'b1, {(STEPS-1){1'b0}}};

   logic [STEPS-1:0] t_state_q, t_state_d;
   logic             halted_q, halted_d;
   logic [2:0]       last_step;
   logic [STEPS-1:0] last_mask;
   logic             t1, t2, t3, t4, t5, en;

   assign t1 = t_state_q[STEPS-1];
   assign t2 = t_state_q[STEPS-2];
   assign t3 = t_state_q[STEPS-3];
   assign t4 = t_state_q[STEPS-4];
   assign t5 = t_state_q[STEPS-5];
   assign en = run & ~halted_q & ~clear;

   always_comb begin
      last_step = 3'd3;
      case (opcode)
         OP_LDA, OP_STA: last_step = 3'd4;
         OP_ADD, OP_SUB: last_step = 3'd5;
         default:        last_step = 3'd3;
      endcase
      last_mask = T1 >> (last_step - 3'd1);
   end

   // bit 0 wrap is a safety net for rings longer than the longest instruction
   always_comb begin
      t_state_d = t_state_q;
      halted_d  = halted_q;
      if (clear) begin
         t_state_d = T1;
         halted_d  = 1'b0;
      end else if (run && !halted_q) begin
         if (t_state_q[0] || (t_state_q & last_mask) != '0) t_state_d = T1;
         else                                               t_state_d = t_state_q >> 1;
         if (t3 && opcode == OP_HLT) halted_d = 1'b1;
      end
   end

   always_ff @(negedge clk) begin
      t_state_q <= t_state_d;
      halted_q  <= halted_d;
   end

   always_comb begin
      pc_inc = 1'b0; pc_out = 1'b0; pc_load = 1'b0; mar_load = 1'b0;
      ram_out = 1'b0; ram_we = 1'b0; ir_load = 1'b0; ir_out = 1'b0;
      a_load = 1'b0; a_out = 1'b0; b_load = 1'b0; alu_out = 1'b0;
      alu_sub = 1'b0; out_load = 1'b0;
      if (en) begin
         if (t1) begin
            pc_out = 1'b1; mar_load = 1'b1;
         end
         if (t2) begin
            ram_out = 1'b1; ir_load = 1'b1; pc_inc = 1'b1;
         end
         if (t3) begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ir_out = 1'b1; mar_load = 1'b1; end
               OP_LDI: begin ir_out = 1'b1; a_load = 1'b1; end
               OP_JMP: begin ir_out = 1'b1; pc_load = 1'b1; end
               OP_OUT: begin a_out = 1'b1; out_load = 1'b1; end
               default: ;
            endcase
         end
         if (t4) begin
            case (opcode)
               OP_LDA:         begin ram_out = 1'b1; a_load = 1'b1; end
               OP_ADD, OP_SUB: begin ram_out = 1'b1; b_load = 1'b1; end
               OP_STA:         begin a_out = 1'b1; ram_we = 1'b1; end
               default: ;
            endcase
         end
         if (t5 && (opcode == OP_ADD || opcode == OP_SUB)) begin
            alu_out = 1'b1; a_load = 1'b1; alu_sub = (opcode == OP_SUB);
         end
      end
   end

   assign t_state = t_state_q;
   assign halted  = halted_q;

endmodule

// File: tb/tb_sap_control_seq.sv
// tb/tb_sap_control_seq.sv - directed bench for sap_control_seq against a step-number model
// The model tracks the instruction step as an integer and looks up the control set per opcode.
module tb_sap_control_seq;

   localparam logic [13:0] C_PC_INC = 14'b1 << 13, C_PC_OUT = 14'b1 << 12, C_PC_LOAD = 14'b1 << 11,
                           C_MAR    = 14'b1 << 10, C_RAM_OUT = 14'b1 << 9, C_RAM_WE  = 14'b1 << 8,
                           C_IR_LD  = 14'b1 << 7,  C_IR_OUT  = 14'b1 << 6, C_A_LOAD  = 14'b1 << 5,
                           C_A_OUT  = 14'b1 << 4,  C_B_LOAD  = 14'b1 << 3, C_ALU_OUT = 14'b1 << 2,
                           C_ALU_SUB = 14'b1 << 1, C_OUT_LD  = 14'b1;

   logic       clk = 1'b0;
   logic       clear = 1'b1, run = 1'b0;
   logic [3:0] opcode = 4'h0;
   logic [5:0] t_state;
   logic       pc_inc, pc_out, pc_load, mar_load, ram_out, ram_we, ir_load, ir_out;
   logic       a_load, a_out, b_load, alu_out, alu_sub, out_load, halted;
   logic [13:0] ctl;

   int passed = 0, total = 0;
   int m_step = 1;
   bit m_halt = 1'b0;
   bit chk_en = 1'b0;

   sap_control_seq #(.STEPS(6), .OPW(4)) dut (
      .clk(clk), .clear(clear), .run(run), .opcode(opcode), .t_state(t_state),
      .pc_inc(pc_inc), .pc_out(pc_out), .pc_load(pc_load), .mar_load(mar_load),
      .ram_out(ram_out), .ram_we(ram_we), .ir_load(ir_load), .ir_out(ir_out),
      .a_load(a_load), .a_out(a_out), .b_load(b_load), .alu_out(alu_out),
      .alu_sub(alu_sub), .out_load(out_load), .halted(halted)
   );

   assign ctl = {pc_inc, pc_out, pc_load, mar_load, ram_out, ram_we, ir_load, ir_out,
                 a_load, a_out, b_load, alu_out, alu_sub, out_load};

   always #5 clk = ~clk;

   function automatic int instr_len(input logic [3:0] op);
      case (op)
         4'h1, 4'h4: return 4;
         4'h2, 4'h3: return 5;
         default:    return 3;
      endcase
   endfunction

   function automatic logic [13:0] exp_ctl(input int step, input logic [3:0] op,
                                           input bit r, input bit c, input bit h);
      if (!r || c || h) return '0;
      if (step == 1) return C_PC_OUT | C_MAR;
      if (step == 2) return C_RAM_OUT | C_IR_LD | C_PC_INC;
      case (op)
         4'h1: return step == 3 ? (C_IR_OUT | C_MAR) : (C_RAM_OUT | C_A_LOAD);
         4'h2: return step == 3 ? (C_IR_OUT | C_MAR) : step == 4 ? (C_RAM_OUT | C_B_LOAD)
                                                                  : (C_ALU_OUT | C_A_LOAD);
         4'h3: return step == 3 ? (C_IR_OUT | C_MAR) : step == 4 ? (C_RAM_OUT | C_B_LOAD)
                                                                  : (C_ALU_OUT | C_A_LOAD | C_ALU_SUB);
         4'h4: return step == 3 ? (C_IR_OUT | C_MAR) : (C_A_OUT | C_RAM_WE);
         4'h5: return C_IR_OUT | C_A_LOAD;
         4'h6: return C_IR_OUT | C_PC_LOAD;
         4'hE: return C_A_OUT | C_OUT_LD;
         default: return '0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (clear) begin
         m_step <= 1;
         m_halt <= 1'b0;
      end else if (run && !m_halt) begin
         if (m_step >= instr_len(opcode)) begin
            m_step <= 1;
            if (opcode == 4'hF) m_halt <= 1'b1;
         end else begin
            m_step <= m_step + 1;
         end
      end
   end

   task automatic check(input string name, input logic [13:0] act, input logic [13:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: actual=%b required=%b at %0t", name, act, req, $time);
   endtask

   always begin
      @(posedge clk);
      #1;
      if (chk_en) begin
         check("model_t_state", 14'(t_state), 14'(6'b1 << (6 - m_step)));
         check("model_ctl", ctl, exp_ctl(m_step, opcode, run, clear, m_halt));
         check("model_halted", 14'(halted), 14'(m_halt));
      end
   end

   task automatic go(input bit c, input bit r, input logic [3:0] op);
      clear = c; run = r; opcode = op;
      @(negedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $display("%0d/%0d checks passed", passed, total + 1);
      $fatal(1);
   end

   initial begin
      go(1, 1, 4'h0);
      go(1, 1, 4'h0);
      chk_en = 1'b1;
      check("reset_t_state", 14'(t_state), 14'(6'b100000));
      check("reset_ctl", ctl, 14'h0);
      check("reset_halted", 14'(halted), 14'h0);

      go(0, 1, 4'h2);
      check("fetch_t2", 14'(t_state), 14'(6'b010000));
      check("fetch_t2_ctl", ctl, C_RAM_OUT | C_IR_LD | C_PC_INC);
      go(0, 1, 4'h2);
      check("add_t3", 14'(t_state), 14'(6'b001000));
      go(0, 1, 4'h2);
      check("add_t4", 14'(t_state), 14'(6'b000100));
      go(0, 1, 4'h2);
      check("add_t5", 14'(t_state), 14'(6'b000010));
      check("add_t5_ctl", ctl, C_ALU_OUT | C_A_LOAD);
      go(0, 1, 4'h2);
      check("add_back_t1", 14'(t_state), 14'(6'b100000));

      for (int i = 0; i < 4; i++) go(0, 1, 4'h3);
      check("sub_t5_ctl", ctl, C_ALU_OUT | C_A_LOAD | C_ALU_SUB);
      go(0, 1, 4'h3);

      for (int i = 0; i < 4; i++) go(0, 1, 4'h1);
      check("lda_back_t1", 14'(t_state), 14'(6'b100000));

      begin
         logic [3:0] shorts [4];
         shorts = '{4'h5, 4'h6, 4'hE, 4'h9};
         foreach (shorts[k]) begin
            go(0, 1, shorts[k]);
            go(0, 1, shorts[k]);
            if (shorts[k] == 4'h6) check("jmp_t3_ctl", ctl, C_IR_OUT | C_PC_LOAD);
            go(0, 1, shorts[k]);
            check($sformatf("short_%h_t1", shorts[k]), 14'(t_state), 14'(6'b100000));
         end
      end

      for (int i = 0; i < 3; i++) go(0, 1, 4'h1);
      for (int i = 0; i < 3; i++) go(0, 0, 4'h1);
      check("pause_t_state", 14'(t_state), 14'(6'b000100));
      check("pause_ctl", ctl, 14'h0);
      run = 1'b1;
      #1;
      check("resume_ctl", ctl, C_RAM_OUT | C_A_LOAD);
      go(0, 1, 4'h1);
      check("resume_t1", 14'(t_state), 14'(6'b100000));

      for (int i = 0; i < 3; i++) go(0, 1, 4'hF);
      check("hlt_halted", 14'(halted), 14'h1);
      for (int i = 0; i < 10; i++) go(0, 1, 4'hF);
      check("hlt_frozen", 14'(t_state), 14'(6'b100000));
      check("hlt_ctl", ctl, 14'h0);
      go(1, 1, 4'hF);
      check("clear_halt", 14'(halted), 14'h0);
      go(0, 1, 4'h0);
      check("resume_after_clear", 14'(t_state), 14'(6'b010000));
      go(0, 1, 4'h0);

      chk_en = 1'b0;
      @(posedge clk);
      #2;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
